// File: rtl/uart_xmtr_arbiter_if.sv
// Bus between the byte producers, the round-robin arbiter and UART_XMTR.
// The master side is the arbiter. The slave side is the environment: producers
// plus the transmitter.
interface uart_xmtr_arbiter_if #(
    parameter int word_size = 8,
    parameter int N_REQ     = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic                       Tx_enable;
    logic [N_REQ-1:0]           Req;
    logic [N_REQ*word_size-1:0] Req_data;
    logic [N_REQ-1:0]           Ack;
    logic [word_size-1:0]       Data_bus;
    logic                       Load_XMT_datareg;
    logic                       Byte_ready;
    logic                       T_byte;
    logic                       Busy;
    logic [IDW-1:0]             Grant_id;

    modport master (
        input  Tx_enable, Req, Req_data,
        output Ack, Data_bus, Load_XMT_datareg, Byte_ready, T_byte, Busy, Grant_id
    );

    modport slave (
        output Tx_enable, Req, Req_data,
        input  Ack, Data_bus, Load_XMT_datareg, Byte_ready, T_byte, Busy, Grant_id
    );
endinterface

// File: rtl/uart_xmtr_arbiter.sv
// Round-robin scheduler sharing one UART_XMTR between N_REQ byte producers.
// It grants one requester and captures its byte. It then sequences
// Load_XMT_datareg -> Byte_ready -> T_byte, waits out the serial frame plus an
// optional idle gap, and only then considers the next grant.
module uart_xmtr_arbiter #(
    parameter int word_size  = 8,
    parameter int N_REQ      = 4,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   Clock,
    input  logic                   rst_b,
    uart_xmtr_arbiter_if.master    bus
);
    localparam int TX_CYCLES = (word_size + 2) * BIT_CYCLES;
    localparam int IDW       = $clog2(N_REQ);
    localparam int CNT_MAX   = (TX_CYCLES > GAP_CYCLES) ? TX_CYCLES : GAP_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {IDLE, LOAD, READY, START, WAIT, GAP} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [IDW-1:0]       last;
    logic [IDW-1:0]       gid_q;
    logic [word_size-1:0] hold;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 load_q, load_d;
    logic                 rdy_q, rdy_d;
    logic                 tbyte_q, tbyte_d;
    logic                 busy_q, busy_d;

    logic                 grant_hit;
    logic                 grant;
    logic [IDW-1:0]       winner;
    logic [IDW-1:0]       cand_idx;
    int                   cand;

    // Round-robin search starting just after the last winner, wrapping around
    always_comb begin
        grant_hit = 1'b0;
        winner    = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            cand_idx = IDW'(cand);
            if (!grant_hit && bus.Req[cand_idx]) begin
                grant_hit = 1'b1;
                winner    = cand_idx;
            end
        end
    end

    assign grant = (state == IDLE) && bus.Tx_enable && grant_hit;

    // State register; reset aborts any frame in progress immediately
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: fixed three-step handshake, then frame and gap timeouts
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = LOAD;
            LOAD:    state_nx = READY;
            READY:   state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode, one cycle ahead so that every output leaves a flop
    always_comb begin
        ack_d = '0;
        if (grant) ack_d[winner] = 1'b1;
        load_d  = (state == LOAD);
        rdy_d   = (state == READY);
        tbyte_d = (state == START);
        busy_d  = (state_nx != IDLE);
    end

    // Frame/gap down-counter: loaded on entry to WAIT and GAP, exit at zero
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else begin
            case (state)
                START:   cnt <= CW'(TX_CYCLES - 1);
                WAIT:    cnt <= (cnt == '0) ? CW'(GAP_LOAD) : cnt - 1'b1;
                GAP:     if (cnt != '0) cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Output flops plus grant bookkeeping; byte is captured only at the grant edge
    always_ff @(posedge Clock or negedge rst_b) begin
        if (!rst_b) begin
            ack_q   <= '0;
            load_q  <= 1'b0;
            rdy_q   <= 1'b0;
            tbyte_q <= 1'b0;
            busy_q  <= 1'b0;
            hold    <= '0;
            gid_q   <= '0;
            last    <= IDW'(N_REQ - 1);
        end else begin
            ack_q   <= ack_d;
            load_q  <= load_d;
            rdy_q   <= rdy_d;
            tbyte_q <= tbyte_d;
            busy_q  <= busy_d;
            if (grant) begin
                hold  <= bus.Req_data[int'(winner)*word_size +: word_size];
                gid_q <= winner;
                last  <= winner;
            end
        end
    end

    assign bus.Ack              = ack_q;
    assign bus.Data_bus         = hold;
    assign bus.Load_XMT_datareg = load_q;
    assign bus.Byte_ready       = rdy_q;
    assign bus.T_byte           = tbyte_q;
    assign bus.Busy             = busy_q;
    assign bus.Grant_id         = gid_q;
endmodule
